// File: rtl/revo_phase_lock_controller.sv
// revo_phase_lock_controller: acquires, confirms and tracks the revo phase from 4-bit edge-pulse words,
// commits the BUFGMUX select once per lock and flywheels a synthesized revo strobe through holdover.
// Ports: clock/reset (async active-high), pll_locked (level), pulse_stream (one revo word per clock);
// select2 (BUFGMUX select), select4 (committed pattern), phase_locked (LOCKED only), revo_out/revo_fake
// (one-cycle strobe and its synthesized flag), state (0..4), mismatch_count (saturating reject count).
module revo_phase_lock_controller #(
  parameter int REVO_PERIOD_WORDS = 1280,
  parameter int CONFIRM_COUNT = 4,
  parameter int MISSING_LIMIT = 3,
  parameter int COUNTER_WIDTH = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pll_locked,
  input  logic [3:0] pulse_stream,
  output logic [1:0] select2,
  output logic [3:0] select4,
  output logic       phase_locked,
  output logic       revo_out,
  output logic       revo_fake,
  output logic [2:0] state,
  output logic [7:0] mismatch_count
);
  typedef enum logic [2:0] {WAIT_PLL, ACQUIRE, CONFIRM, LOCKED, HOLDOVER} state_t;
  localparam logic [COUNTER_WIDTH-1:0] PM1 = COUNTER_WIDTH'(REVO_PERIOD_WORDS - 1);
  localparam logic [COUNTER_WIDTH-1:0] P2M1 = COUNTER_WIDTH'(2 * REVO_PERIOD_WORDS - 1);
  localparam logic [7:0] CC = 8'(CONFIRM_COUNT);
  localparam logic [7:0] ML = 8'(MISSING_LIMIT);
  state_t st;
  logic [3:0] cand;
  logic [7:0] conf, miss;
  logic [COUNTER_WIDTH-1:0] cnt;
  logic valid, bad, at_end, hit, match, rej;
  assign state = st;
  assign valid = pulse_stream inside {4'hF, 4'hE, 4'hC, 4'h8};
  assign bad = |pulse_stream && !valid;
  assign at_end = cnt == PM1;
  assign hit = valid && at_end && pulse_stream == select4;
  assign match = at_end && pulse_stream == cand;
  // a valid word that the current state refuses: off-period/different in CONFIRM, not the tracked revo when locked
  assign rej = valid && ((st == CONFIRM && !match) || ((st == LOCKED || st == HOLDOVER) && !hit));
  function automatic logic [1:0] dec(input logic [3:0] w);
    return w == 4'hF ? 2'd0 : w == 4'hE ? 2'd1 : w == 4'hC ? 2'd2 : 2'd3;
  endfunction
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st <= WAIT_PLL;
      select2 <= '0;
      select4 <= '0;
      phase_locked <= 1'b0;
      revo_out <= 1'b0;
      revo_fake <= 1'b0;
      mismatch_count <= '0;
      cand <= '0;
      conf <= '0;
      miss <= '0;
      cnt <= '0;
    end else begin
      revo_out <= 1'b0;
      revo_fake <= 1'b0;
      if (pll_locked && (bad || rej) && ~&mismatch_count) mismatch_count <= mismatch_count + 8'd1;
      if (!pll_locked) begin
        st <= WAIT_PLL;
        phase_locked <= 1'b0;
      end else begin
        case (st)
          WAIT_PLL: st <= ACQUIRE;
          ACQUIRE: if (valid) begin
            cand <= pulse_stream;
            conf <= 8'd1;
            cnt <= '0;
            st <= CONFIRM;
          end
          CONFIRM: if (valid && match) begin
            cnt <= '0;
            conf <= conf + 8'd1;
            if (conf + 8'd1 >= CC) begin
              select4 <= cand;
              select2 <= dec(cand);
              miss <= '0;
              phase_locked <= 1'b1;
              st <= LOCKED;
            end
          end else if (valid) begin
            cand <= pulse_stream;
            conf <= 8'd1;
            cnt <= '0;
          end else if (cnt == P2M1) st <= ACQUIRE;
          else cnt <= cnt + COUNTER_WIDTH'(1);
          LOCKED, HOLDOVER: begin
            cnt <= at_end ? '0 : cnt + COUNTER_WIDTH'(1);
            if (st == HOLDOVER && rej) st <= ACQUIRE;
            else if (at_end) begin
              revo_out <= 1'b1;
              revo_fake <= !hit;
              if (hit) begin
                miss <= '0;
                phase_locked <= 1'b1;
                st <= LOCKED;
              end else begin
                miss <= miss + 8'd1 >= ML ? ML : miss + 8'd1;
                if (miss + 8'd1 >= ML) begin
                  phase_locked <= 1'b0;
                  st <= HOLDOVER;
                end
              end
            end
          end
          default: st <= WAIT_PLL;
        endcase
      end
    end
  end
endmodule
